conductance_synapse_array: RTL and testbench
============================================

Name: conductance_synapse_array

Overview:
- Multi-channel conductance-based synapse block for one dendrite compartment: NUM_CH channels, each holding its own conductance state g_i, reversal potential E_i, weight and decay shift.
- Per tick: decays each g_i exponentially, adds weight on a pending spike, computes I = sum(g_i*(E_i - vmem)) on one time-multiplexed multiplier, and presents a saturated current.
- Channel parameters load through a daisy-chained serial config shift chain.

Parameters:
- WORD_LENGTH, 16, data word width (signed fixed point, Q(W-FRAC_BITS).FRAC_BITS).
- FRAC_BITS, WORD_LENGTH/2, fractional bits; product is scaled by arithmetic shift right FRAC_BITS.
- NUM_CH, 4, number of synapse channels (>=1).
- DECAY_WIDTH, 4, used LSBs of the decay config word.

Ports:
- clk  in  1  single system clock.
- reset  in  1  asynchronous, active-high reset.
- input_spike  in  NUM_CH  per-channel spike pulses, any cycle.
- tick  in  1  one-cycle integration-step strobe.
- vmem  in  WORD_LENGTH  signed membrane voltage; sampled at tick.
- cfg_en  in  1  shift-enable for the config chain.
- cfg_data_in  in  WORD_LENGTH  config word into the chain.
- cfg_data_out  out  WORD_LENGTH  chain tail, to the next block.
- output_current  out  WORD_LENGTH  signed saturated synaptic current.
- current_valid  out  1  one-cycle pulse: output_current updated.
- busy  out  1  computation in progress.
- tick_overrun  out  1  sticky: a tick arrived while busy.

Behaviour:
- Reset (async, any time, including mid-computation): all g_i, config regs, pending bits, accumulator, outputs = 0; FSM to IDLE; no current_valid is issued for an aborted computation.
- Config chain:
  - 3*NUM_CH word registers, order cfg_data_in -> ch0.E -> ch0.weight -> ch0.decay -> ch1.E ... -> ch(NUM_CH-1).decay -> cfg_data_out.
  - Shifts one word per clk with cfg_en=1.
  - cfg_en is ignored while busy=1.
- Spike capture:
  - pending[i] is set when input_spike[i]=1.
  - On an accepted tick: snap = pending | input_spike, and pending is cleared in the same edge.
  - Spikes arriving while busy accumulate in pending for the next tick; multiple spikes per step count once.
- FSM:
  - IDLE -> CALC on tick; vmem is snapshotted and the accumulator cleared.
  - CALC runs NUM_CH cycles, channel index 0..NUM_CH-1.
  - CALC -> FLUSH for 1 cycle, draining the 2-stage pipeline.
  - FLUSH -> DONE for 1 cycle: output_current registered, current_valid=1.
  - DONE -> IDLE.
  - busy=1 in CALC, FLUSH and DONE.
- Tick while busy: ignored and sets tick_overrun, which is cleared only by reset. A tick in the DONE cycle also counts as overrun.
- Latency: tick sampled at edge k gives current_valid high during the cycle after edge k+NUM_CH+2. The next tick is accepted from edge k+NUM_CH+3.
- Stage 1 (channel i, edge k+1+i):
  - If decay=0: g_i unchanged (no decay).
  - Otherwise: g_i <= g_i - (g_i >> decay) + (snap[i] ? weight_i : 0).
  - g_i is unsigned WORD_LENGTH and saturates at 2^W-1.
  - diff_i = E_i - vmem_snap, signed W+1 bits, no saturation.
- Stage 2 (edge k+2+i):
  - term = (zero-extended g_i * diff_i) >>> FRAC_BITS, signed.
  - The accumulator is wide enough for NUM_CH maximal terms and never wraps.
- Output: the accumulator saturates to signed WORD_LENGTH, range [0x8000, 0x7FFF] at W=16.
- output_current holds its value between updates.

Decomposition:
- Shared fixed-point package: WORD_LENGTH, FRAC_BITS, word/wide typedefs, signed saturate-to-word function, unsigned saturating add function, FSM state enum.
- One sub-module, syn_cfg_chain: parametrised word shift register with enable. It exposes parallel per-channel E/weight/decay and cfg_data_out, and is reusable across synapse blocks.

Test Plan (W=16, FRAC_BITS=8, NUM_CH=4, other channels zeroed):
- Basic current:
  - Stimulus: ch0 E=0x0400, weight=0x0100, decay=0; vmem=0; spike ch0, then tick at edge k.
  - Response: current_valid in cycle after k+6, output_current=0x0400, busy high for exactly 6 cycles.
- Decay:
  - Stimulus: ch0 decay=1, weight=0x0100, E=0x0400, vmem=0; spike+tick, then two ticks without spikes.
  - Response: output_current sequence 0x0400, 0x0200, 0x0100.
- Saturation:
  - Stimulus: all channels weight=0xFFFF, decay=0, E=0x7FFF, vmem=0x8000; spike twice across ticks.
  - Response: g stays 0xFFFF, output_current=0x7FFF. With E=0x8000, vmem=0x7FFF: output_current=0x8000.
- Overrun and spike during busy:
  - Stimulus: tick, then second tick at k+3 with input_spike[1] at k+2.
  - Response: single current_valid, tick_overrun=1. Ch1 spike applied only at the next accepted tick.
- Config chain:
  - Stimulus: shift 12 distinct words, then 12 more.
  - Response: cfg_data_out emits the first 12 words in order. cfg_en pulses during busy leave all registers unchanged.
- Reset mid-computation:
  - Stimulus: reset asserted at k+2.
  - Response: no current_valid; output_current=0, busy=0, all g=0. The next tick yields output_current=0 with no spikes.

Source files
------------

// File: rtl/conductance_synapse_array_pkg.sv
// Shared fixed-point definitions for the conductance synapse block: widths,
// word types, saturation helpers and the sequencing FSM states.
package conductance_synapse_array_pkg;

  localparam int WORD_LENGTH = 16;
  localparam int FRAC_BITS   = WORD_LENGTH / 2;
  localparam int NUM_CH      = 4;
  localparam int DECAY_WIDTH = 4;
  localparam int SAT_IN_W    = 64;

  typedef logic [WORD_LENGTH-1:0]      word_t;
  typedef logic signed [SAT_IN_W-1:0]  wide_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FLUSH,
    ST_DONE
  } syn_state_e;

  // Clamp a wide signed value into the signed word range.
  function automatic word_t sat_word(input wide_t v);
    wide_t max_v;
    wide_t min_v;
    max_v = (wide_t'(1) <<< (WORD_LENGTH - 1)) - wide_t'(1);
    min_v = -(wide_t'(1) <<< (WORD_LENGTH - 1));
    if (v > max_v)
      return {1'b0, {(WORD_LENGTH-1){1'b1}}};
    else if (v < min_v)
      return {1'b1, {(WORD_LENGTH-1){1'b0}}};
    else
      return v[WORD_LENGTH-1:0];
  endfunction

  function automatic word_t sat_add_u(input word_t a, input word_t b);
    logic [WORD_LENGTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[WORD_LENGTH] ? {WORD_LENGTH{1'b1}} : s[WORD_LENGTH-1:0];
  endfunction

endpackage

// File: rtl/conductance_synapse_array_cfg_chain.sv
// Daisy-chained per-channel parameter shift register (E, weight, decay per channel),
// exposing every channel's fields in parallel.
module syn_cfg_chain #(
  parameter int WORD_LENGTH = 16,
  parameter int NUM_CH      = 4,
  parameter int DECAY_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          shift_en,
  input  logic [WORD_LENGTH-1:0]        cfg_data_in,
  output logic [WORD_LENGTH-1:0]        cfg_data_out,
  output logic [NUM_CH*WORD_LENGTH-1:0] cfg_e,
  output logic [NUM_CH*WORD_LENGTH-1:0] cfg_weight,
  output logic [NUM_CH*DECAY_WIDTH-1:0] cfg_decay
);

  localparam int DEPTH = 3 * NUM_CH;

  logic [WORD_LENGTH-1:0] chain [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < DEPTH; j++) chain[j] <= '0;
    end else if (shift_en) begin
      chain[0] <= cfg_data_in;
      for (int j = 1; j < DEPTH; j++) chain[j] <= chain[j-1];
    end
  end

  assign cfg_data_out = chain[DEPTH-1];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign cfg_e[c*WORD_LENGTH +: WORD_LENGTH]      = chain[3*c];
    assign cfg_weight[c*WORD_LENGTH +: WORD_LENGTH] = chain[3*c+1];
    assign cfg_decay[c*DECAY_WIDTH +: DECAY_WIDTH]  = chain[3*c+2][DECAY_WIDTH-1:0];
  end

endmodule

// File: rtl/conductance_synapse_array.sv
// Multi-channel conductance synapse: per tick, decays/charges each g_i and sums
// g_i*(E_i - vmem) through one shared multiplier into a saturated current.
//
// state    | meaning
// ST_IDLE  | waiting for tick
// ST_CALC  | one channel per cycle through stage 1 (g update, E - vmem)
// ST_FLUSH | last product drains into the accumulator
// ST_DONE  | accumulator saturated into output_current on exit
module conductance_synapse_array #(
  parameter int WORD_LENGTH = conductance_synapse_array_pkg::WORD_LENGTH,
  parameter int FRAC_BITS   = conductance_synapse_array_pkg::FRAC_BITS,
  parameter int NUM_CH      = conductance_synapse_array_pkg::NUM_CH,
  parameter int DECAY_WIDTH = conductance_synapse_array_pkg::DECAY_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CH-1:0]      input_spike,
  input  logic                   tick,
  input  logic [WORD_LENGTH-1:0] vmem,
  input  logic                   cfg_en,
  input  logic [WORD_LENGTH-1:0] cfg_data_in,
  output logic [WORD_LENGTH-1:0] cfg_data_out,
  output logic [WORD_LENGTH-1:0] output_current,
  output logic                   current_valid,
  output logic                   busy,
  output logic                   tick_overrun
);

  import conductance_synapse_array_pkg::*;

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PROD_W = 2 * WORD_LENGTH + 2;
  localparam int ACC_W  = PROD_W + CH_W + 1;
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

  logic [NUM_CH*WORD_LENGTH-1:0] cfg_e;
  logic [NUM_CH*WORD_LENGTH-1:0] cfg_weight;
  logic [NUM_CH*DECAY_WIDTH-1:0] cfg_decay;

  syn_state_e state_q, state_d;
  logic [CH_W-1:0]        ch_idx;
  logic [NUM_CH-1:0]      pending;
  logic [NUM_CH-1:0]      snap;
  logic [WORD_LENGTH-1:0] vmem_snap;
  logic [WORD_LENGTH-1:0] g [NUM_CH];

  logic                        s1_valid;
  logic [WORD_LENGTH-1:0]      s1_g;
  logic signed [WORD_LENGTH:0] s1_diff;
  logic signed [ACC_W-1:0]     acc;

  logic tick_accept;

  assign busy        = (state_q != ST_IDLE);
  assign tick_accept = tick && (state_q == ST_IDLE);

  syn_cfg_chain #(
    .WORD_LENGTH(WORD_LENGTH),
    .NUM_CH     (NUM_CH),
    .DECAY_WIDTH(DECAY_WIDTH)
  ) u_cfg_chain (
    .clk         (clk),
    .reset       (reset),
    .shift_en    (cfg_en && !busy),
    .cfg_data_in (cfg_data_in),
    .cfg_data_out(cfg_data_out),
    .cfg_e       (cfg_e),
    .cfg_weight  (cfg_weight),
    .cfg_decay   (cfg_decay)
  );

  // Stage 1 operands for the channel selected by ch_idx.
  logic [WORD_LENGTH-1:0]      g_cur, e_cur, w_cur, g_decayed, g_next;
  logic [DECAY_WIDTH-1:0]      d_cur;
  logic signed [WORD_LENGTH:0] diff_cur;

  always_comb begin
    g_cur     = g[ch_idx];
    e_cur     = cfg_e[int'(ch_idx)*WORD_LENGTH +: WORD_LENGTH];
    w_cur     = cfg_weight[int'(ch_idx)*WORD_LENGTH +: WORD_LENGTH];
    d_cur     = cfg_decay[int'(ch_idx)*DECAY_WIDTH +: DECAY_WIDTH];
    g_decayed = (d_cur == '0) ? g_cur : g_cur - (g_cur >> d_cur);
    g_next    = sat_add_u(g_decayed, snap[ch_idx] ? w_cur : '0);
    diff_cur  = $signed({e_cur[WORD_LENGTH-1], e_cur})
              - $signed({vmem_snap[WORD_LENGTH-1], vmem_snap});
  end

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  term;

  always_comb begin
    prod = PROD_W'($signed({1'b0, s1_g})) * PROD_W'(s1_diff);
    term = ACC_W'(prod >>> FRAC_BITS);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (tick) state_d = ST_CALC;
      ST_CALC:  if (ch_idx == CH_LAST) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_idx         <= '0;
      pending        <= '0;
      snap           <= '0;
      vmem_snap      <= '0;
      for (int i = 0; i < NUM_CH; i++) g[i] <= '0;
      s1_valid       <= 1'b0;
      s1_g           <= '0;
      s1_diff        <= '0;
      acc            <= '0;
      output_current <= '0;
      current_valid  <= 1'b0;
      tick_overrun   <= 1'b0;
    end else begin
      if (tick_accept) begin
        vmem_snap <= vmem;
        snap      <= pending | input_spike;
        pending   <= '0;
        acc       <= '0;
        ch_idx    <= '0;
      end else begin
        pending <= pending | input_spike;
      end

      if (state_q == ST_CALC) begin
        g[ch_idx] <= g_next;
        s1_g      <= g_next;
        s1_diff   <= diff_cur;
        ch_idx    <= ch_idx + CH_W'(1);
      end
      s1_valid <= (state_q == ST_CALC);

      if (s1_valid) acc <= acc + term;

      current_valid <= (state_q == ST_DONE);
      if (state_q == ST_DONE) output_current <= sat_word(wide_t'(acc));

      if (tick && busy) tick_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conductance_synapse_array.sv
// Bench for conductance_synapse_array: directed scenarios with literal results
// plus randomized traffic compared every cycle against a tick-level model.
module tb_conductance_synapse_array;

  localparam int W   = 16;
  localparam int NCH = 4;
  localparam int FB  = 8;
  localparam int LAT = NCH + 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NCH-1:0] input_spike = '0;
  logic           tick = 1'b0;
  logic [W-1:0]   vmem = '0;
  logic           cfg_en = 1'b0;
  logic [W-1:0]   cfg_data_in = '0;
  logic [W-1:0]   cfg_data_out;
  logic [W-1:0]   output_current;
  logic           current_valid;
  logic           busy;
  logic           tick_overrun;

  always #5 clk = ~clk;

  conductance_synapse_array #(
    .WORD_LENGTH(W), .FRAC_BITS(FB), .NUM_CH(NCH), .DECAY_WIDTH(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .input_spike   (input_spike),
    .tick          (tick),
    .vmem          (vmem),
    .cfg_en        (cfg_en),
    .cfg_data_in   (cfg_data_in),
    .cfg_data_out  (cfg_data_out),
    .output_current(output_current),
    .current_valid (current_valid),
    .busy          (busy),
    .tick_overrun  (tick_overrun)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Tick-level reference: config image indexed by chain position, conductances,
  // pending spikes and a countdown of busy cycles.
  logic [W-1:0]   m_cfg [3*NCH];
  longint         m_g [NCH];
  logic [NCH-1:0] m_pend = '0;
  int             m_cnt = 0;
  logic           m_valid = 1'b0;
  logic           m_ovr = 1'b0;
  logic [W-1:0]   m_out = '0;
  logic [W-1:0]   m_res = '0;

  initial begin
    for (int j = 0; j < 3*NCH; j++) m_cfg[j] = '0;
    for (int c = 0; c < NCH; c++) m_g[c] = 0;
  end

  task automatic model_calc(input logic [NCH-1:0] snp, input logic [W-1:0] v,
                            output logic [W-1:0] res);
    longint sum, g, diff;
    int d;
    sum = 0;
    for (int c = 0; c < NCH; c++) begin
      d = int'(m_cfg[3*c+2] & 16'h000F);
      g = m_g[c];
      if (d != 0) g = g - (g >> d);
      if (snp[c]) g = g + longint'(m_cfg[3*c+1]);
      if (g > 65535) g = 65535;
      m_g[c] = g;
      diff = longint'($signed(m_cfg[3*c])) - longint'($signed(v));
      sum += (g * diff) >>> FB;
    end
    if (sum > 32767)       res = 16'h7FFF;
    else if (sum < -32768) res = 16'h8000;
    else                   res = sum[W-1:0];
  endtask

  always @(posedge clk) begin : mdl
    logic pb;
    logic [NCH-1:0] snp;
    if (reset) begin
      for (int j = 0; j < 3*NCH; j++) m_cfg[j] = '0;
      for (int c = 0; c < NCH; c++) m_g[c] = 0;
      m_pend = '0; m_cnt = 0; m_valid = 1'b0; m_ovr = 1'b0; m_out = '0;
    end else begin
      pb = (m_cnt > 0);
      m_valid = 1'b0;
      if (cfg_en && !pb) begin
        for (int j = 3*NCH-1; j > 0; j--) m_cfg[j] = m_cfg[j-1];
        m_cfg[0] = cfg_data_in;
      end
      if (pb) begin
        if (tick) m_ovr = 1'b1;
        m_cnt--;
        if (m_cnt == 0) begin
          m_valid = 1'b1;
          m_out = m_res;
        end
        m_pend = m_pend | input_spike;
      end else if (tick) begin
        snp = m_pend | input_spike;
        m_pend = '0;
        model_calc(snp, vmem, m_res);
        m_cnt = LAT;
      end else begin
        m_pend = m_pend | input_spike;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    check("cmp_valid", current_valid, m_valid);
    check("cmp_busy", busy, longint'(m_cnt > 0));
    check("cmp_overrun", tick_overrun, m_ovr);
    check("cmp_current", output_current, m_out);
    check("cmp_cfg_out", cfg_data_out, m_cfg[3*NCH-1]);
  end

  // Directed-scenario helpers; every task starts and ends just after a negedge.
  logic [W-1:0] img [3*NCH];

  task automatic clear_img();
    for (int j = 0; j < 3*NCH; j++) img[j] = '0;
  endtask

  task automatic set_ch(input int ch, input logic [W-1:0] e, input logic [W-1:0] w,
                        input logic [W-1:0] d);
    img[3*ch] = e; img[3*ch+1] = w; img[3*ch+2] = d;
  endtask

  task automatic load_img();
    for (int j = 3*NCH-1; j >= 0; j--) begin
      cfg_en = 1'b1; cfg_data_in = img[j];
      @(negedge clk);
    end
    cfg_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_spike(input logic [NCH-1:0] m);
    input_spike = m;
    @(negedge clk);
    input_spike = '0;
  endtask

  task automatic run_tick(input logic [NCH-1:0] spk, input logic [W-1:0] v,
                          output logic [W-1:0] val, output int busy_cyc);
    logic seen;
    seen = 1'b0; val = '0; busy_cyc = 0;
    input_spike = spk; tick = 1'b1; vmem = v;
    @(posedge clk);
    for (int n = 0; n < 20 && !seen; n++) begin
      #1;
      if (current_valid) begin
        seen = 1'b1;
        val = output_current;
      end else if (busy) busy_cyc++;
      @(negedge clk);
      tick = 1'b0; input_spike = '0;
      if (!seen) @(posedge clk);
    end
    check("valid_timeout", seen, 1);
  endtask

  logic [W-1:0] val;
  int           bc;
  int           nvalid;
  logic [W-1:0] wa [3*NCH];
  logic [W-1:0] wb [3*NCH];

  initial begin
    do_reset();
    check("rst_current", output_current, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", tick_overrun, 0);
    check("rst_cfg_out", cfg_data_out, 0);

    // basic current
    clear_img(); set_ch(0, 16'h0400, 16'h0100, 16'h0000); load_img();
    pulse_spike(4'b0001);
    run_tick(4'b0000, 16'h0000, val, bc);
    check("basic_current", val, 16'h0400);
    check("basic_busy_cycles", bc, 6);

    // exponential decay with shift 1
    do_reset();
    clear_img(); set_ch(0, 16'h0400, 16'h0100, 16'h0001); load_img();
    run_tick(4'b0001, 16'h0000, val, bc); check("decay_0", val, 16'h0400);
    run_tick(4'b0000, 16'h0000, val, bc); check("decay_1", val, 16'h0200);
    run_tick(4'b0000, 16'h0000, val, bc); check("decay_2", val, 16'h0100);

    // conductance and output saturation
    do_reset();
    clear_img();
    for (int c = 0; c < NCH; c++) set_ch(c, 16'h7FFF, 16'hFFFF, 16'h0000);
    load_img();
    run_tick(4'b1111, 16'h8000, val, bc); check("sat_pos_0", val, 16'h7FFF);
    run_tick(4'b1111, 16'h8000, val, bc); check("sat_pos_1", val, 16'h7FFF);
    for (int c = 0; c < NCH; c++) set_ch(c, 16'h8000, 16'hFFFF, 16'h0000);
    load_img();
    run_tick(4'b0000, 16'h7FFF, val, bc); check("sat_neg", val, 16'h8000);

    // overrun with a channel-1 spike during busy
    do_reset();
    clear_img();
    set_ch(0, 16'h0400, 16'h0100, 16'h0000);
    set_ch(1, 16'h0200, 16'h0100, 16'h0000);
    load_img();
    input_spike = 4'b0001; tick = 1'b1; vmem = '0;
    @(negedge clk); tick = 1'b0; input_spike = '0;
    @(negedge clk); input_spike = 4'b0010;
    @(negedge clk); input_spike = '0; tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    nvalid = 0; val = '0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (current_valid) begin nvalid++; val = output_current; end
    end
    @(negedge clk);
    check("ovr_valid_count", nvalid, 1);
    check("ovr_current", val, 16'h0400);
    check("ovr_flag", tick_overrun, 1);
    run_tick(4'b0000, 16'h0000, val, bc);
    check("ovr_next_current", val, 16'h0600);
    check("ovr_flag_sticky", tick_overrun, 1);

    // config chain pass-through and busy lockout
    do_reset();
    for (int j = 0; j < 3*NCH; j++) begin
      wa[j] = {4'(j + 1), 12'($urandom)};
      wb[j] = {4'(j + 1), 12'($urandom)};
    end
    for (int j = 0; j < 3*NCH; j++) begin
      cfg_en = 1'b1; cfg_data_in = wa[j];
      @(negedge clk);
    end
    for (int j = 0; j < 3*NCH; j++) begin
      check("chain_out", cfg_data_out, wa[j]);
      cfg_data_in = wb[j];
      @(negedge clk);
    end
    cfg_en = 1'b0;
    tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    for (int n = 0; n < 4; n++) begin
      cfg_en = 1'b1; cfg_data_in = 16'($urandom);
      @(negedge clk);
    end
    cfg_en = 1'b0;
    for (int n = 0; n < 4; n++) @(negedge clk);
    check("busy_cfg_hold", cfg_data_out, wb[0]);

    // reset in the middle of a computation
    do_reset();
    clear_img(); set_ch(0, 16'h0400, 16'h0100, 16'h0000); load_img();
    input_spike = 4'b0001; tick = 1'b1;
    @(negedge clk); tick = 1'b0; input_spike = '0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); @(negedge clk); reset = 1'b0;
    nvalid = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (current_valid) nvalid++;
    end
    @(negedge clk);
    check("rstmid_no_valid", nvalid, 0);
    check("rstmid_current", output_current, 0);
    check("rstmid_busy", busy, 0);
    load_img();
    run_tick(4'b0000, 16'h0000, val, bc);
    check("rstmid_next_current", val, 16'h0000);

    // randomized traffic, checked every cycle against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      tick        = ($urandom_range(0, 5) == 0);
      input_spike = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
      vmem        = 16'($urandom);
      cfg_en      = ($urandom_range(0, 3) == 0);
      cfg_data_in = 16'($urandom);
      reset       = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    reset = 1'b0; tick = 1'b0; input_spike = '0; cfg_en = 1'b0;
    for (int n = 0; n < 10; n++) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
